// File: rtl/datamem_mmio.sv
// Data memory with a memory-mapped I/O window: byte-writable RAM, R/W output
// registers, 2-flop synchronised input ports, 1-cycle registered reads.
// Optional change-detect STATUS word enabled by defining DATAMEM_MMIO_STATUS_EN.
module datamem_mmio #(
    parameter int unsigned DM_AW = 5,
    parameter int unsigned N_OUT = 3,
    parameter int unsigned N_IN  = 2
) (
    input  logic                  mem_clk,
    input  logic                  clr,
    input  logic                  req,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [31:0]           addr,
    input  logic [31:0]           datain,
    output logic [31:0]           dataout,
    output logic                  rvalid,
    input  logic [N_IN*32-1:0]    in_port,
    output logic [N_OUT*32-1:0]   out_port
);

    localparam int unsigned DEPTH = 1 << DM_AW;

    logic                      io_sel;
    logic [DM_AW-1:0]          w;
    logic                      rd_c;
    logic                      wr_c;
    logic [31:0]               rd_data_c;
    logic [31:0]               ram [DEPTH];
    logic [N_OUT-1:0][31:0]    out_reg;
    logic [N_IN-1:0][31:0]     sync1;
    logic [N_IN-1:0][31:0]     sync2;
    logic                      unused_addr;

    assign io_sel      = addr[DM_AW+2];
    assign w           = addr[DM_AW+1:2];
    assign rd_c        = req & ~we;
    assign wr_c        = req & we;
    assign out_port    = out_reg;
    assign unused_addr = ^{addr[31:DM_AW+3], addr[1:0]};

`ifdef DATAMEM_MMIO_STATUS_EN
    localparam logic [DM_AW-1:0] STATUS_W = DM_AW'(DEPTH - 1);

    logic [N_IN-1:0][31:0]     sync3;
    logic [N_IN-1:0]           status_q;
    logic [N_IN-1:0]           chg_c;
    logic                      stat_rd_c;

    assign stat_rd_c = rd_c & io_sel & (w == STATUS_W);

    // Change detect: synchronised value differs from its previous-cycle copy
    always_comb begin
        chg_c = '0;
        for (int j = 0; j < int'(N_IN); j++) begin
            chg_c[j] = (sync2[j] != sync3[j]);
        end
    end

    // Sticky change flags, cleared by a STATUS read; a new event wins
    always_ff @(posedge mem_clk or posedge clr) begin
        if (clr) begin
            sync3    <= '0;
            status_q <= '0;
        end else begin
            sync3    <= sync2;
            status_q <= (stat_rd_c ? '0 : status_q) | chg_c;
        end
    end
`endif

    // Byte-enabled RAM write; contents are intentionally not reset
    always_ff @(posedge mem_clk) begin
        if (wr_c && !io_sel) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram[w][8*b +: 8] <= datain[8*b +: 8];
            end
        end
    end

    // Byte-enabled writes to the output registers
    always_ff @(posedge mem_clk or posedge clr) begin
        if (clr) begin
            out_reg <= '0;
        end else if (wr_c && io_sel) begin
            for (int k = 0; k < int'(N_OUT); k++) begin
                if (w == DM_AW'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) out_reg[k][8*b +: 8] <= datain[8*b +: 8];
                    end
                end
            end
        end
    end

    // Two-flop synchroniser for the asynchronous input ports
    always_ff @(posedge mem_clk or posedge clr) begin
        if (clr) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Read mux; unmapped I/O words read as zero
    always_comb begin
        rd_data_c = '0;
        if (!io_sel) begin
            rd_data_c = ram[w];
        end else begin
            for (int k = 0; k < int'(N_OUT); k++) begin
                if (w == DM_AW'(k)) rd_data_c = out_reg[k];
            end
            for (int j = 0; j < int'(N_IN); j++) begin
                if (w == DM_AW'(N_OUT + j)) rd_data_c = sync2[j];
            end
`ifdef DATAMEM_MMIO_STATUS_EN
            if (w == STATUS_W) rd_data_c = 32'(status_q);
`endif
        end
    end

    // Registered read data; dataout holds between reads
    always_ff @(posedge mem_clk or posedge clr) begin
        if (clr) begin
            dataout <= '0;
            rvalid  <= 1'b0;
        end else begin
            rvalid <= rd_c;
            if (rd_c) dataout <= rd_data_c;
        end
    end

endmodule

// File: tb/tb_datamem_mmio.sv
// Self-checking bench for datamem_mmio: directed vector table, randomized
// traffic against a behavioural model, clear-in-flight and STATUS sequences.
module tb_datamem_mmio;

    localparam int unsigned DM_AW = 5;
    localparam int unsigned N_OUT = 3;
    localparam int unsigned N_IN  = 2;
    localparam int unsigned DEPTH = 32;

    logic                  mem_clk = 1'b0;
    logic                  clr;
    logic                  req;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           addr;
    logic [31:0]           datain;
    logic [31:0]           dataout;
    logic                  rvalid;
    logic [N_IN*32-1:0]    in_port;
    logic [N_OUT*32-1:0]   out_port;

    int errors = 0;
    int checks = 0;

    datamem_mmio #(.DM_AW(DM_AW), .N_OUT(N_OUT), .N_IN(N_IN)) dut (
        .mem_clk (mem_clk),
        .clr     (clr),
        .req     (req),
        .we      (we),
        .be      (be),
        .addr    (addr),
        .datain  (datain),
        .dataout (dataout),
        .rvalid  (rvalid),
        .in_port (in_port),
        .out_port(out_port)
    );

    always #5 mem_clk = ~mem_clk;

    // Behavioural model state
    logic [31:0]        m_mem [DEPTH];
    bit   [3:0]         m_def [DEPTH];
    logic [31:0]        m_out [N_OUT];
    logic [N_IN*32-1:0] in_m1, in_m2, in_m3;
    logic [31:0]        e_dout;
    bit                 e_known;
    bit                 e_rv;
    logic [N_IN-1:0]    m_flags;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < int'(N_OUT); k++) m_out[k] = '0;
        in_m1   = '0;
        in_m2   = '0;
        in_m3   = '0;
        e_dout  = '0;
        e_known = 1'b1;
        e_rv    = 1'b0;
        m_flags = '0;
    endtask

    // One rising edge of the reference model
    task automatic model_edge(input bit r, input bit w, input logic [3:0] b,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [N_IN*32-1:0] inp);
        bit io;
        int wi;
        logic [31:0] rv;
        bit known;
        logic [N_IN-1:0] chg;
        io    = a[DM_AW+2];
        wi    = int'(a[DM_AW+1:2]);
        rv    = '0;
        known = 1'b1;
        for (int j = 0; j < int'(N_IN); j++) chg[j] = (in_m2[32*j +: 32] != in_m3[32*j +: 32]);
        if (r && !w) begin
            if (!io) begin
                rv    = m_mem[wi];
                known = (m_def[wi] == 4'hF);
            end else if (wi < int'(N_OUT)) begin
                rv = m_out[wi];
            end else if (wi < int'(N_OUT + N_IN)) begin
                rv = in_m2[32*(wi-int'(N_OUT)) +: 32];
            end
`ifdef DATAMEM_MMIO_STATUS_EN
            else if (wi == int'(DEPTH) - 1) begin
                rv = 32'(m_flags);
            end
`endif
            e_dout  = rv;
            e_known = known;
        end
        e_rv = r && !w;
`ifdef DATAMEM_MMIO_STATUS_EN
        m_flags = ((r && !w && io && wi == int'(DEPTH) - 1) ? '0 : m_flags) | chg;
`endif
        if (r && w) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) begin
                    if (!io) begin
                        m_mem[wi][8*i +: 8] = d[8*i +: 8];
                        m_def[wi][i] = 1'b1;
                    end else if (wi < int'(N_OUT)) begin
                        m_out[wi][8*i +: 8] = d[8*i +: 8];
                    end
                end
            end
        end
        in_m3 = in_m2;
        in_m2 = in_m1;
        in_m1 = inp;
    endtask

    task automatic check_outputs(string tag);
        chk({tag, ":rvalid"}, 32'(rvalid), 32'(e_rv));
        if (e_known) chk({tag, ":dataout"}, dataout, e_dout);
        for (int k = 0; k < int'(N_OUT); k++)
            chk({tag, ":out_port"}, out_port[32*k +: 32], m_out[k]);
    endtask

    task automatic cycle(input bit r, input bit w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [N_IN*32-1:0] inp, input string tag);
        req = r; we = w; be = b; addr = a; datain = d; in_port = inp;
        @(posedge mem_clk);
        model_edge(r, w, b, a, d, inp);
        #1;
        check_outputs(tag);
    endtask

    typedef struct {
        bit          r;
        bit          w;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] in0;
        bit          erv;
        logic [31:0] edo;
    } vec_t;

    vec_t vt [19];
    logic [N_IN*32-1:0] cur;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) m_def[i] = 4'h0;
        clr = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; datain = '0; in_port = '0;
        model_reset();
        #12;
        chk("reset:rvalid", 32'(rvalid), 32'h0);
        chk("reset:dataout", dataout, 32'h0);
        chk("reset:out_port0", out_port[31:0], 32'h0);
        chk("reset:out_port2", out_port[95:64], 32'h0);
        @(negedge mem_clk);
        clr = 1'b0;
        @(posedge mem_clk);
        #1;

        vt[0]  = '{1, 1, 4'hF, 32'h08, 32'h11223344, 32'h0,    0, 32'h0};
        vt[1]  = '{1, 0, 4'h0, 32'h08, 32'h0,        32'h0,    1, 32'h11223344};
        vt[2]  = '{1, 1, 4'h5, 32'h08, 32'hAABBCCDD, 32'h0,    0, 32'h11223344};
        vt[3]  = '{1, 0, 4'h0, 32'h08, 32'h0,        32'h0,    1, 32'h11BB33DD};
        vt[4]  = '{1, 1, 4'hF, 32'h84, 32'h5,        32'h0,    0, 32'h11BB33DD};
        vt[5]  = '{1, 0, 4'h0, 32'h84, 32'h0,        32'h0,    1, 32'h5};
        vt[6]  = '{0, 0, 4'h0, 32'h0,  32'h0,        32'hCAFE, 0, 32'h5};
        vt[7]  = '{0, 0, 4'h0, 32'h0,  32'h0,        32'hCAFE, 0, 32'h5};
        vt[8]  = '{1, 0, 4'h0, 32'h8C, 32'h0,        32'hCAFE, 1, 32'hCAFE};
        vt[9]  = '{1, 0, 4'h0, 32'h90, 32'h0,        32'hCAFE, 1, 32'h0};
        vt[10] = '{1, 0, 4'h0, 32'h94, 32'h0,        32'hCAFE, 1, 32'h0};
        vt[11] = '{0, 0, 4'h0, 32'h0,  32'h0,        32'hCAFE, 0, 32'h0};
        vt[12] = '{1, 1, 4'h0, 32'h08, 32'hFFFFFFFF, 32'hCAFE, 0, 32'h0};
        vt[13] = '{1, 0, 4'h0, 32'h08, 32'h0,        32'hCAFE, 1, 32'h11BB33DD};
        vt[14] = '{1, 1, 4'hF, 32'h0C, 32'h12345678, 32'hCAFE, 0, 32'h11BB33DD};
        vt[15] = '{1, 0, 4'h0, 32'h0C, 32'h0,        32'hCAFE, 1, 32'h12345678};
        vt[16] = '{1, 1, 4'hF, 32'h8C, 32'hDEADBEEF, 32'hCAFE, 0, 32'h12345678};
        vt[17] = '{1, 0, 4'h0, 32'h8C, 32'h0,        32'hCAFE, 1, 32'hCAFE};
`ifdef DATAMEM_MMIO_STATUS_EN
        vt[18] = '{1, 0, 4'h0, 32'hFC, 32'h0,        32'hCAFE, 1, 32'h1};
`else
        vt[18] = '{1, 0, 4'h0, 32'hFC, 32'h0,        32'hCAFE, 1, 32'h0};
`endif

        for (int i = 0; i < 19; i++) begin
            cycle(vt[i].r, vt[i].w, vt[i].b, vt[i].a, vt[i].d, {32'h0, vt[i].in0}, "vec");
            chk($sformatf("vec%0d:rvalid", i), 32'(rvalid), 32'(vt[i].erv));
            chk($sformatf("vec%0d:dataout", i), dataout, vt[i].edo);
        end
        chk("vec:out_port1", out_port[63:32], 32'h5);

        // Randomized traffic against the model
        cur = {32'h0, 32'hCAFE};
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            bit io;
            int wi;
            io = ($urandom % 2) == 1;
            wi = int'($urandom % DEPTH);
            if (io && ($urandom % 3) != 0) wi = ($urandom % 4 == 0) ? 31 : int'($urandom % 6);
            a = $urandom;
            a[DM_AW+2] = io;
            a[DM_AW+1:2] = DM_AW'(wi);
            if ($urandom % 8 == 0) cur = {$urandom, $urandom};
            cycle(($urandom % 4) != 0, ($urandom % 2) == 1, 4'($urandom), a, $urandom, cur, "rand");
        end

`ifdef DATAMEM_MMIO_STATUS_EN
        // Change-detect flag: set, clear-on-read, and set winning over clear
        for (int n = 0; n < 3; n++) cycle(0, 0, 4'h0, 32'h0, 32'h0, cur, "st_idle");
        cycle(1, 0, 4'h0, 32'hFC, 32'h0, cur, "st_clear");
        cur[63:32] = ~cur[63:32];
        for (int n = 0; n < 3; n++) cycle(0, 0, 4'h0, 32'h0, 32'h0, cur, "st_wait");
        cycle(1, 0, 4'h0, 32'hFC, 32'h0, cur, "st_rd1");
        chk("status:set", 32'(dataout[1]), 32'h1);
        cycle(1, 0, 4'h0, 32'hFC, 32'h0, cur, "st_rd2");
        chk("status:cleared", 32'(dataout[1]), 32'h0);
        cur[63:32] = ~cur[63:32];
        cycle(0, 0, 4'h0, 32'h0, 32'h0, cur, "st_tog");
        cycle(0, 0, 4'h0, 32'h0, 32'h0, cur, "st_tog");
        cycle(1, 0, 4'h0, 32'hFC, 32'h0, cur, "st_coinc");
        chk("status:coinc_read", 32'(dataout[1]), 32'h0);
        cycle(1, 0, 4'h0, 32'hFC, 32'h0, cur, "st_after");
        chk("status:set_wins", 32'(dataout[1]), 32'h1);
`endif

        // Clear asserted with reads in flight
        cycle(1, 1, 4'hF, 32'h80, 32'hA5A5A5A5, cur, "clr_pre");
        cycle(1, 0, 4'h0, 32'h80, 32'h0, cur, "clr_rd");
        chk("clr_pre:rvalid", 32'(rvalid), 32'h1);
        req = 1'b1; we = 1'b0; addr = 32'h80;
        #2;
        clr = 1'b1;
        #1;
        chk("clr:rvalid_async", 32'(rvalid), 32'h0);
        chk("clr:dataout_async", dataout, 32'h0);
        chk("clr:out_port0", out_port[31:0], 32'h0);
        @(posedge mem_clk);
        #1;
        chk("clr:rvalid_held", 32'(rvalid), 32'h0);
        model_reset();
        req = 1'b0;
        @(negedge mem_clk);
        clr = 1'b0;
        for (int n = 0; n < 3; n++) cycle(0, 0, 4'h0, 32'h0, 32'h0, cur, "clr_post");
        chk("clr_post:out_port0", out_port[31:0], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
